tweet_relay: RTL

Parametrised successor to the tweetboard serial store-and-forward path. Receives 8N1-style UART bytes on `serial_in`, buffers them in a DEPTH-entry FIFO, and on a debounced press of `btn_write` retransmits the buffered bytes on `serial_out` at the same baud rate. Baud, data width, buffer depth and debounce time are generic. Overflow and framing-error reporting and an optional parity mode are added.

---
 rtl/tweet_relay.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tweet_relay.sv
// tweet_relay: UART byte store-and-forward; RX bytes queue in a DEPTH FIFO, a debounced button drains them on TX.
// Latency: byte counted 1 cycle after its stop sample; TX starts 1 cycle after debounced press. No backpressure: full FIFO drops and flags overflow.
// Build option TWEET_RELAY_PARITY_EN adds an even-parity bit to RX and TX frames.
module tweet_relay #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BAUD         = 9600,
    parameter int DATA_BITS    = 8,
    parameter int DEPTH        = 16,
    parameter int DEBOUNCE_CYC = 50_000
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     serial_in,
    input  logic                     btn_write,
    output logic                     serial_out,
    output logic                     in_debug,
    output logic                     out_debug,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     frame_err
);
    localparam int BIT_CYC  = CLK_HZ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
`ifdef TWEET_RELAY_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NB = DATA_BITS + PAR_BITS;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(BIT_CYC + 1);
    localparam int IW = $clog2(NB + 1);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);
    localparam logic [IW-1:0] NB_LAST   = IW'(NB - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // rx_sync_q[2] is the previous synchronised sample, used for start-edge detection
    logic [2:0] rx_sync_q;
    logic [1:0] btn_sync_q;
    logic       rx_s, rx_fall, btn_s;

    assign rx_s    = rx_sync_q[1];
    assign rx_fall = rx_sync_q[2] & ~rx_sync_q[1];
    assign btn_s   = btn_sync_q[1];

    logic          db_level_q, db_level_d, db_rise;
    logic [DW-1:0] db_cnt_q, db_cnt_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [IW-1:0] rx_idx_q, rx_idx_d;
    logic [NB-1:0] rx_sh_q, rx_sh_d;
    logic          rx_push, rx_bad, rx_par_ok;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 fifo_full, fifo_pop, push_ok;
    logic [DATA_BITS-1:0] head;
    logic [NB-1:0]        tx_frame;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [IW-1:0] tx_idx_q, tx_idx_d;
    logic [NB-1:0] tx_sh_q, tx_sh_d;
    logic [AW:0]   tx_left_q, tx_left_d;
    logic          drain_q, drain_d, tx_line_d, ov_clr;

    logic serial_out_q, in_debug_q, overflow_q, overflow_d, frame_err_q;

    assign fifo_full = (count_q == FULL_CNT);
    assign push_ok   = rx_push & (~fifo_full | fifo_pop);
    assign head      = mem_q[rd_ptr_q];

`ifdef TWEET_RELAY_PARITY_EN
    assign rx_par_ok = ~^rx_sh_q;
    assign tx_frame  = {^head, head};
`else
    assign rx_par_ok = 1'b1;
    assign tx_frame  = head;
`endif

    always_comb begin
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (btn_s != db_level_q) begin
            if (db_cnt_q == DB_LAST) db_level_d = btn_s;
            else                     db_cnt_d   = db_cnt_q + 1'b1;
        end
        db_rise = db_level_d & ~db_level_q;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_idx_d   = rx_idx_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        rx_bad     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_idx_d   = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == BIT_LAST) begin
                rx_cnt_d = '0;
                rx_sh_d  = {rx_s, rx_sh_q[NB-1:1]};
                rx_idx_d = rx_idx_q + 1'b1;
                if (rx_idx_q == NB_LAST) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == BIT_LAST) begin
                rx_state_d = RX_IDLE;
                if (rx_s && rx_par_ok) rx_push = 1'b1;
                else                   rx_bad  = 1'b1;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Drain length is snapshotted at start so bytes arriving mid-drain wait for the next press
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_idx_d   = tx_idx_q;
        tx_sh_d    = tx_sh_q;
        tx_left_d  = tx_left_q;
        drain_d    = drain_q;
        fifo_pop   = 1'b0;
        ov_clr     = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (db_rise && count_q != '0) begin
                    fifo_pop   = 1'b1;
                    tx_sh_d    = tx_frame;
                    tx_left_d  = count_q;
                    drain_d    = 1'b1;
                    ov_clr     = 1'b1;
                    tx_state_d = TX_START;
                end
            end
            TX_START: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d   = '0;
                tx_idx_d   = '0;
                tx_state_d = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                tx_sh_d  = {1'b0, tx_sh_q[NB-1:1]};
                tx_idx_d = tx_idx_q + 1'b1;
                if (tx_idx_q == NB_LAST) tx_state_d = TX_STOP;
            end
            TX_STOP: if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d  = '0;
                tx_left_d = tx_left_q - 1'b1;
                if (tx_left_q == ONE_CNT) begin
                    drain_d    = 1'b0;
                    tx_state_d = TX_IDLE;
                end else begin
                    fifo_pop   = 1'b1;
                    tx_sh_d    = tx_frame;
                    tx_state_d = TX_START;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_sh_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (ov_clr) overflow_d = 1'b0;
        if (rx_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
    end

    always_ff @(posedge sysclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= rx_sh_q[DATA_BITS-1:0];
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_sync_q    <= '1;
            btn_sync_q   <= '0;
            db_level_q   <= 1'b0;
            db_cnt_q     <= '0;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_idx_q     <= '0;
            rx_sh_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_idx_q     <= '0;
            tx_sh_q      <= '0;
            tx_left_q    <= '0;
            drain_q      <= 1'b0;
            serial_out_q <= 1'b1;
            in_debug_q   <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_sync_q    <= {rx_sync_q[1:0], serial_in};
            btn_sync_q   <= {btn_sync_q[0], btn_write};
            db_level_q   <= db_level_d;
            db_cnt_q     <= db_cnt_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_idx_q     <= rx_idx_d;
            rx_sh_q      <= rx_sh_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_idx_q     <= tx_idx_d;
            tx_sh_q      <= tx_sh_d;
            tx_left_q    <= tx_left_d;
            drain_q      <= drain_d;
            serial_out_q <= tx_line_d;
            in_debug_q   <= (rx_state_d != RX_IDLE);
            overflow_q   <= overflow_d;
            frame_err_q  <= rx_bad;
            if (push_ok)  wr_ptr_q <= wr_ptr_q + 1'b1;
            if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, fifo_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign serial_out = serial_out_q;
    assign in_debug   = in_debug_q;
    assign out_debug  = drain_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule
